// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Used by uart_rx_param and uart_rx_sampler.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // Receive deframer states; PARITY is only reachable when UART_RX_PARITY_EN is defined
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_e;

    // Two-out-of-three majority used for the mid-bit vote
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Serial input conditioning: 2-flop synchroniser and 3-sample mid-bit vote.
// Samples are captured at ticks HALF-1 and HALF; the vote output combines
// them with the current synchronised level, so it is valid on tick HALF+1.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int   OVERSAMPLE = UART_OVERSAMPLE,
    localparam int  TICK_W     = $clog2(OVERSAMPLE)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              rx_clk_en,
    input  logic              rx,
    input  logic [TICK_W-1:0] tick,
    output logic              rx_s,
    output logic              vote
);

    localparam int HALF = OVERSAMPLE / 2;
    localparam logic [TICK_W-1:0] TICK_LO  = TICK_W'(HALF - 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(HALF);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic samp_lo_q, samp_lo_d;
    logic samp_mid_q, samp_mid_d;

    // Next-state for the synchroniser chain and the two early vote samples
    always_comb begin
        sync1_d    = rx;
        sync2_d    = sync1_q;
        samp_lo_d  = samp_lo_q;
        samp_mid_d = samp_mid_q;
        if (rx_clk_en && (tick == TICK_LO)) begin
            samp_lo_d = sync2_q;
        end else begin
            samp_lo_d = samp_lo_q;
        end
        if (rx_clk_en && (tick == TICK_MID)) begin
            samp_mid_d = sync2_q;
        end else begin
            samp_mid_d = samp_mid_q;
        end
    end

    // Sampler registers; idle-high line level after reset
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            samp_lo_q  <= 1'b1;
            samp_mid_q <= 1'b1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            samp_lo_q  <= samp_lo_d;
            samp_mid_q <= samp_mid_d;
        end
    end

    assign rx_s = sync2_q;
    assign vote = maj3(samp_lo_q, samp_mid_q, sync2_q);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled deframing, ready/clear handshake,
// sticky framing/overrun (and optional parity) error flags.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after the
// data bits, the PARITY_ODD parameter and the parity_err port.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int STOP_BITS  = 1
`ifdef UART_RX_PARITY_EN
    ,
    parameter int PARITY_ODD = 0
`endif
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 rx_clk_en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_ready,
    input  logic                 rx_ready_clear,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam int HALF   = OVERSAMPLE / 2;

    localparam logic [TICK_W-1:0] TICK_ZERO = {TICK_W{1'b0}};
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(HALF);
    localparam logic [TICK_W-1:0] TICK_VOTE = TICK_W'(HALF + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    localparam logic [BIT_W-1:0]  BIT_DLAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_SLAST = BIT_W'(STOP_BITS - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
`endif

    rx_state_e             state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_err_q, overrun_err_d;
    logic                  parity_err_q, parity_err_d;

    logic rx_s;
    logic vote_s;
    logic deliver_s;
    logic set_frame_s;
    logic set_par_s;
    logic set_ovr_s;

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .rx_clk_en (rx_clk_en),
        .rx        (rx),
        .tick      (tick_q),
        .rx_s      (rx_s),
        .vote      (vote_s)
    );

    // Deframer next-state: advances only on oversample ticks
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        deliver_s   = 1'b0;
        set_frame_s = 1'b0;
        set_par_s   = 1'b0;
        if (rx_clk_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        tick_d  = TICK_ZERO;
                    end else begin
                        state_d = IDLE;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was noise
                    if ((tick_q == TICK_MID) && rx_s) begin
                        state_d = IDLE;
                        tick_d  = TICK_ZERO;
                    end else if (tick_q == TICK_LAST) begin
                        state_d = DATA;
                        tick_d  = TICK_ZERO;
                        bit_d   = BIT_ZERO;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_VOTE) begin
                        shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
                    end else begin
                        shift_d = shift_q;
                    end
                    if (tick_q == TICK_LAST) begin
                        tick_d = TICK_ZERO;
                        if (bit_q == BIT_DLAST) begin
                            bit_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    // Parity mismatch is flagged but the word is still delivered
                    if ((tick_q == TICK_VOTE) && (vote_s != ((^shift_q) ^ PAR_ODD))) begin
                        set_par_s = 1'b1;
                    end else begin
                        set_par_s = 1'b0;
                    end
                    if (tick_q == TICK_LAST) begin
                        state_d = STOP;
                        tick_d  = TICK_ZERO;
                        bit_d   = BIT_ZERO;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
`endif
                STOP: begin
                    if (tick_q == TICK_VOTE) begin
                        if (!vote_s) begin
                            set_frame_s = 1'b1;
                            state_d     = BREAK;
                            tick_d      = TICK_ZERO;
                            bit_d       = BIT_ZERO;
                        end else if (bit_q == BIT_SLAST) begin
                            deliver_s = 1'b1;
                            state_d   = IDLE;
                            tick_d    = TICK_ZERO;
                            bit_d     = BIT_ZERO;
                        end else begin
                            tick_d = tick_q + TICK_ONE;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_d = TICK_ZERO;
                        bit_d  = bit_q + BIT_ONE;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = BREAK;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tick_d  = TICK_ZERO;
                    bit_d   = BIT_ZERO;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Host handshake and sticky flags; a flag being set wins over a clear
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_ready_d = rx_ready_q;
        set_ovr_s  = 1'b0;
        if (deliver_s) begin
            if (!rx_ready_q || rx_ready_clear) begin
                rx_data_d  = shift_q;
                rx_ready_d = 1'b1;
            end else begin
                set_ovr_s = 1'b1;
            end
        end else if (rx_ready_clear) begin
            rx_ready_d = 1'b0;
        end else begin
            rx_ready_d = rx_ready_q;
        end

        if (set_frame_s) begin
            frame_err_d = 1'b1;
        end else if (rx_ready_clear) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end

        if (set_ovr_s) begin
            overrun_err_d = 1'b1;
        end else if (rx_ready_clear) begin
            overrun_err_d = 1'b0;
        end else begin
            overrun_err_d = overrun_err_q;
        end

        if (set_par_s) begin
            parity_err_d = 1'b1;
        end else if (rx_ready_clear) begin
            parity_err_d = 1'b0;
        end else begin
            parity_err_d = parity_err_q;
        end
    end

    // State, counters and output registers
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q       <= IDLE;
            tick_q        <= TICK_ZERO;
            bit_q         <= BIT_ZERO;
            shift_q       <= {DATA_BITS{1'b0}};
            rx_data_q     <= {DATA_BITS{1'b0}};
            rx_ready_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            parity_err_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_q        <= tick_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_ready_q    <= rx_ready_d;
            frame_err_q   <= frame_err_d;
            overrun_err_q <= overrun_err_d;
            parity_err_q  <= parity_err_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_ready    = rx_ready_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed self-checking bench for uart_rx_param.
// Instance a: default 8 data / 16x / 1 stop. Instance b: 7 data / 8x / 2 stop.
// Parity cases are built only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_param;
    import uart_pkg::*;

    logic       sys_clk;
    logic       rst;
    logic       rx_clk_en;
    logic       rx_a, rx_b;
    logic       clr_a, clr_b;
    logic [7:0] rx_data_a;
    logic [6:0] rx_data_b;
    logic       rx_ready_a, rx_ready_b;
    logic       frame_err_a, frame_err_b;
    logic       overrun_err_a, overrun_err_b;
`ifdef UART_RX_PARITY_EN
    logic       parity_err_a, parity_err_b;
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_param dut_a (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .rx_clk_en      (rx_clk_en),
        .rx             (rx_a),
        .rx_data        (rx_data_a),
        .rx_ready       (rx_ready_a),
        .rx_ready_clear (clr_a),
        .frame_err      (frame_err_a),
        .overrun_err    (overrun_err_a)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err     (parity_err_a)
`endif
    );

    uart_rx_param #(
        .DATA_BITS  (7),
        .OVERSAMPLE (8),
        .STOP_BITS  (2)
    ) dut_b (
        .sys_clk        (sys_clk),
        .rst            (rst),
        .rx_clk_en      (rx_clk_en),
        .rx             (rx_b),
        .rx_data        (rx_data_b),
        .rx_ready       (rx_ready_b),
        .rx_ready_clear (clr_b),
        .frame_err      (frame_err_b),
        .overrun_err    (overrun_err_b)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err     (parity_err_b)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Guard against a stuck run
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int nd_of(input int sel);
        return (sel == 0) ? 8 : 7;
    endfunction

    function automatic int os_of(input int sel);
        return (sel == 0) ? 16 : 8;
    endfunction

    function automatic int ns_of(input int sel);
        return (sel == 0) ? 1 : 2;
    endfunction

    // Frame tick index (0 = start detect) at which rx_ready should rise
    function automatic int exp_rise(input int sel);
        int n;
        n = 1 + nd_of(sel) + NPAR + ns_of(sel);
        return 1 + os_of(sel) * (n - 1) + os_of(sel) / 2 + 1;
    endfunction

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? rx_ready_a : rx_ready_b;
    endfunction

    // One oversample tick; rx settles through the synchroniser beforehand
    task automatic tick(input int sel, input bit clr);
        repeat (3) @(negedge sys_clk);
        rx_clk_en = 1'b1;
        if (clr) begin
            if (sel == 0) clr_a = 1'b1;
            else          clr_b = 1'b1;
        end
        @(negedge sys_clk);
        rx_clk_en = 1'b0;
        clr_a     = 1'b0;
        clr_b     = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        rx_a = 1'b1;
        rx_b = 1'b1;
        for (int i = 0; i < n; i++) tick(0, 1'b0);
    endtask

    task automatic clear_pulse(input int sel);
        @(negedge sys_clk);
        if (sel == 0) clr_a = 1'b1;
        else          clr_b = 1'b1;
        @(negedge sys_clk);
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    // Send one frame; optionally clear or reset at a given frame tick
    task automatic send_frame(input int sel, input logic [7:0] data, input bit par_flip,
                              input logic [1:0] stop_vals, input int clr_at,
                              input int rst_at, output int rise);
        logic [31:0] fb;
        logic        par;
        logic        prev, cur;
        int          n, f;
        fb  = 32'h0;
        par = 1'b0;
        for (int i = 0; i < nd_of(sel); i++) begin
            fb[1 + i] = data[i];
            par       = par ^ data[i];
        end
        n = 1 + nd_of(sel);
        if (NPAR == 1) begin
            fb[n] = par ^ par_flip;
            n     = n + 1;
        end
        for (int s = 0; s < ns_of(sel); s++) fb[n + s] = stop_vals[s];
        n    = n + ns_of(sel);
        rise = -1;
        prev = ready_of(sel);
        f    = 0;
        for (int b = 0; b < n; b++) begin
            if (sel == 0) rx_a = fb[b];
            else          rx_b = fb[b];
            for (int j = 0; j < os_of(sel); j++) begin
                tick(sel, f == clr_at);
                if (f == rst_at) begin
                    rst = 1'b1;
                    @(negedge sys_clk);
                    rst = 1'b0;
                    check("rst_mid_data",  32'(rx_data_a),     32'h0);
                    check("rst_mid_ready", 32'(rx_ready_a),    32'h0);
                    check("rst_mid_ferr",  32'(frame_err_a),   32'h0);
                    check("rst_mid_oerr",  32'(overrun_err_a), 32'h0);
`ifdef UART_RX_PARITY_EN
                    check("rst_mid_perr",  32'(parity_err_a),  32'h0);
`endif
                    rx_a = 1'b1;
                    rx_b = 1'b1;
                    return;
                end
                cur = ready_of(sel);
                if (!prev && cur && (rise < 0)) rise = f;
                prev = cur;
                f++;
            end
        end
        rx_a = 1'b1;
        rx_b = 1'b1;
    endtask

    initial begin
        int rise;
        rst       = 1'b1;
        rx_clk_en = 1'b0;
        rx_a      = 1'b1;
        rx_b      = 1'b1;
        clr_a     = 1'b0;
        clr_b     = 1'b0;
        repeat (4) @(negedge sys_clk);
        check("reset_data",  32'(rx_data_a),     32'h0);
        check("reset_ready", 32'(rx_ready_a),    32'h0);
        check("reset_ferr",  32'(frame_err_a),   32'h0);
        check("reset_oerr",  32'(overrun_err_a), 32'h0);
        check("reset_state", 32'(dut_a.state_q), 32'(IDLE));
        rst = 1'b0;
        idle_ticks(4);

        // Two normal frames with a clear in between
        send_frame(0, 8'h55, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("f55_rise",  32'(rise),          32'(exp_rise(0)));
        check("f55_data",  32'(rx_data_a),     32'h55);
        check("f55_ready", 32'(rx_ready_a),    32'h1);
        check("f55_ferr",  32'(frame_err_a),   32'h0);
        clear_pulse(0);
        check("f55_clr_ready", 32'(rx_ready_a), 32'h0);
        send_frame(0, 8'hA3, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("fa3_rise",  32'(rise),          32'(exp_rise(0)));
        check("fa3_data",  32'(rx_data_a),     32'hA3);
        check("fa3_oerr",  32'(overrun_err_a), 32'h0);
        check("fa3_ferr",  32'(frame_err_a),   32'h0);
        clear_pulse(0);

        // Short low glitch must fall back to idle
        rx_a = 1'b0;
        for (int i = 0; i < 4; i++) tick(0, 1'b0);
        idle_ticks(16);
        check("glitch_state", 32'(dut_a.state_q), 32'(IDLE));
        check("glitch_ready", 32'(rx_ready_a),    32'h0);
        check("glitch_ferr",  32'(frame_err_a),   32'h0);

        // Stop bit low: framing error, old data kept; then a good frame
        send_frame(0, 8'h3C, 1'b0, 2'b00, -1, -1, rise);
        idle_ticks(4);
        check("f3c_ferr",  32'(frame_err_a), 32'h1);
        check("f3c_ready", 32'(rx_ready_a),  32'h0);
        check("f3c_data",  32'(rx_data_a),   32'hA3);
        check("f3c_rise",  32'(rise),        32'hFFFFFFFF);
        send_frame(0, 8'h81, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("f81_rise",  32'(rise),       32'(exp_rise(0)));
        check("f81_data",  32'(rx_data_a),  32'h81);
        clear_pulse(0);
        check("f81_clr_ferr",  32'(frame_err_a), 32'h0);
        check("f81_clr_ready", 32'(rx_ready_a),  32'h0);

        // Overrun: second word arrives while the first is still pending
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        send_frame(0, 8'h22, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("ovr_data",  32'(rx_data_a),     32'h11);
        check("ovr_oerr",  32'(overrun_err_a), 32'h1);
        check("ovr_ready", 32'(rx_ready_a),    32'h1);
        clear_pulse(0);
        check("ovr_clr_ready", 32'(rx_ready_a),    32'h0);
        check("ovr_clr_oerr",  32'(overrun_err_a), 32'h0);

        // Clear coinciding with delivery accepts the new word
        send_frame(0, 8'h11, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        send_frame(0, 8'h22, 1'b0, 2'b11, exp_rise(0), -1, rise);
        idle_ticks(4);
        check("clrdel_data",  32'(rx_data_a),     32'h22);
        check("clrdel_ready", 32'(rx_ready_a),    32'h1);
        check("clrdel_oerr",  32'(overrun_err_a), 32'h0);
        clear_pulse(0);

        // 7 data bits, 8x oversample, two stop bits
        send_frame(1, 8'h5A, 1'b0, 2'b01, -1, -1, rise);
        idle_ticks(4);
        check("b5a_stop2_ferr",  32'(frame_err_b), 32'h1);
        check("b5a_stop2_ready", 32'(rx_ready_b),  32'h0);
        send_frame(1, 8'h5A, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("b5a_rise",  32'(rise),       32'(exp_rise(1)));
        check("b5a_data",  32'(rx_data_b),  32'h5A);
        check("b5a_ready", 32'(rx_ready_b), 32'h1);

        // Word 0x07 (parity bit wrong when parity is built in)
        send_frame(0, 8'h07, 1'b1, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("f07_data",  32'(rx_data_a),  32'h07);
        check("f07_ready", 32'(rx_ready_a), 32'h1);
`ifdef UART_RX_PARITY_EN
        check("f07_perr",  32'(parity_err_a), 32'h1);
`endif

        // Reset in the middle of the data bits, then a clean frame
        send_frame(0, 8'h0F, 1'b0, 2'b11, -1, 40, rise);
        idle_ticks(24);
        send_frame(0, 8'hF0, 1'b0, 2'b11, -1, -1, rise);
        idle_ticks(4);
        check("ff0_rise",  32'(rise),          32'(exp_rise(0)));
        check("ff0_data",  32'(rx_data_a),     32'hF0);
        check("ff0_ready", 32'(rx_ready_a),    32'h1);
        check("ff0_oerr",  32'(overrun_err_a), 32'h0);
`ifdef UART_RX_PARITY_EN
        check("ff0_perr",  32'(parity_err_a),  32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
